// File: rtl/tiny_alu_pkg.sv
// Shared types and defaults for the tiny_alu arbiter: opcode and FSM state
// encodings, default widths, and the opcode classifier used at dispatch.
package tiny_alu_pkg;

  localparam int DATA_W_DEF      = 8;
  localparam int TIMEOUT_CYC_DEF = 16;

  typedef enum logic [2:0] {
    NOP = 3'b000,
    ADD = 3'b001,
    AND = 3'b010,
    XOR = 3'b011,
    MUL = 3'b100,
    RST = 3'b111
  } alu_op_e;

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    RESP
  } arb_state_e;

  // Only ADD..MUL reach the ALU; NOP, RST and the unused codes finish locally.
  function automatic logic is_alu_op(input logic [2:0] op);
    return (op == ADD) || (op == AND) || (op == XOR) || (op == MUL);
  endfunction

endpackage

// File: rtl/tiny_alu_rr_pick.sv
// Combinational round-robin selector: starting at ptr and wrapping, returns
// the first requester with valid set as a one-hot grant plus its index.
module tiny_alu_rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] valid,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  int k;

  // Walk the requesters from ptr upward and take the first one asking
  always_comb begin
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    k     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NUM_REQ) k = k - NUM_REQ;
      if (!any && valid[k]) begin
        any      = 1'b1;
        grant[k] = 1'b1;
        idx      = PTR_W'(k);
      end
    end
  end

endmodule

// File: rtl/tiny_alu_arbiter.sv
// Round-robin arbiter sharing one tiny_alu between NUM_REQ requesters.
// One transaction at a time: IDLE arbitrates, BUSY runs the ALU handshake,
// RESP returns a one-cycle result pulse to the owner. NOP/RST and unused
// opcodes complete locally with result 0.
// Optional feature: define TINY_ALU_ARB_TIMEOUT_EN to add a BUSY watchdog
// that aborts after TIMEOUT_CYC cycles and flags resp_error_o.
module tiny_alu_arbiter
  import tiny_alu_pkg::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = DATA_W_DEF,
  parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic                      clk_i,
  input  logic                      reset_n_i,
  input  logic [NUM_REQ-1:0]        req_valid_i,
  output logic [NUM_REQ-1:0]        req_ready_o,
  input  logic [NUM_REQ*DATA_W-1:0] req_a_i,
  input  logic [NUM_REQ*DATA_W-1:0] req_b_i,
  input  logic [NUM_REQ*3-1:0]      req_op_i,
  output logic [NUM_REQ-1:0]        resp_valid_o,
  output logic [2*DATA_W-1:0]       resp_result_o,
  output logic                      resp_error_o,
  output logic                      alu_start_o,
  output logic [2:0]                alu_op_o,
  output logic [DATA_W-1:0]         alu_a_o,
  output logic [DATA_W-1:0]         alu_b_o,
  input  logic                      alu_done_i,
  input  logic [2*DATA_W-1:0]       alu_result_i
);

  localparam int PTR_W = $clog2(NUM_REQ);
  localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

  if (NUM_REQ < 2 || TIMEOUT_CYC < 1) begin : g_cfg_check
    $error("tiny_alu_arbiter: NUM_REQ must be >= 2 and TIMEOUT_CYC >= 1");
  end

  arb_state_e          state;
  logic [PTR_W-1:0]    ptr;
  logic [PTR_W-1:0]    owner;
  logic [PTR_W-1:0]    ptr_next;
  logic [NUM_REQ-1:0]  pick_grant;
  logic [PTR_W-1:0]    pick_idx;
  logic                pick_any;
  logic                accept;
  logic [2:0]          pick_op;
  logic [DATA_W-1:0]   pick_a;
  logic [DATA_W-1:0]   pick_b;
  logic [NUM_REQ-1:0]  owner_oh;

  tiny_alu_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_pick (
    .valid (req_valid_i),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  // Grant is only offered while idle; a transfer is any granted valid.
  assign req_ready_o = (state == IDLE) ? pick_grant : '0;
  assign accept      = (state == IDLE) && pick_any;

  assign pick_op  = req_op_i[int'(pick_idx)*3 +: 3];
  assign pick_a   = req_a_i[int'(pick_idx)*DATA_W +: DATA_W];
  assign pick_b   = req_b_i[int'(pick_idx)*DATA_W +: DATA_W];
  assign ptr_next = (pick_idx == LAST_IDX) ? '0 : pick_idx + 1'b1;

  // Decode the owner index into the response strobe position
  always_comb begin
    owner_oh        = '0;
    owner_oh[owner] = 1'b1;
  end

`ifdef TINY_ALU_ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

  logic [CNT_W-1:0] to_cnt;
  logic             to_hit;

  // Hit on the TIMEOUT_CYC-th BUSY cycle that ends without done.
  assign to_hit = (to_cnt == CNT_W'(TIMEOUT_CYC - 1));

  // Watchdog: cleared at accept, counts BUSY cycles that end without done
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      to_cnt <= '0;
    end else if (accept) begin
      to_cnt <= '0;
    end else if (state == BUSY && !alu_done_i) begin
      to_cnt <= to_cnt + CNT_W'(1);
    end
  end
`else
  assign resp_error_o = 1'b0;
`endif

  // Transaction FSM with registered ALU handshake and response outputs
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state         <= IDLE;
      ptr           <= '0;
      owner         <= '0;
      alu_start_o   <= 1'b0;
      alu_op_o      <= '0;
      alu_a_o       <= '0;
      alu_b_o       <= '0;
      resp_valid_o  <= '0;
      resp_result_o <= '0;
`ifdef TINY_ALU_ARB_TIMEOUT_EN
      resp_error_o  <= 1'b0;
`endif
    end else begin
      resp_valid_o <= '0;
`ifdef TINY_ALU_ARB_TIMEOUT_EN
      resp_error_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (accept) begin
            owner    <= pick_idx;
            ptr      <= ptr_next;
            alu_op_o <= pick_op;
            alu_a_o  <= pick_a;
            alu_b_o  <= pick_b;
            if (is_alu_op(pick_op)) begin
              state       <= BUSY;
              alu_start_o <= 1'b1;
            end else begin
              state         <= RESP;
              resp_valid_o  <= pick_grant;
              resp_result_o <= '0;
            end
          end
        end
        BUSY: begin
          if (alu_done_i) begin
            state         <= RESP;
            alu_start_o   <= 1'b0;
            resp_valid_o  <= owner_oh;
            resp_result_o <= alu_result_i;
          end
`ifdef TINY_ALU_ARB_TIMEOUT_EN
          else if (to_hit) begin
            state         <= RESP;
            alu_start_o   <= 1'b0;
            resp_valid_o  <= owner_oh;
            resp_result_o <= '0;
            resp_error_o  <= 1'b1;
          end
`endif
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          alu_start_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/tiny_alu_arbiter.md
# tiny_alu_arbiter

Shares one tiny_alu instance between NUM_REQ independent requesters, one transaction at a time. The block sits between the requester ports and the tiny_alu operand/start/done pins, in the same clk_i/reset_n_i domain as the ALU. It picks requesters round-robin, drives the ALU start handshake, captures the result and returns it to the granted requester. NOP/RST opcodes complete locally without touching the ALU.

## Interface
Parameters:
- NUM_REQ, 4: number of requesters; must be at least 2.
- DATA_W, 8: operand width. Result width is 2*DATA_W.
- TIMEOUT_CYC, 16: watchdog limit in cycles. Used only with TINY_ALU_ARB_TIMEOUT_EN.

Ports:
- clk_i  in  1  single clock; all logic on its rising edge.
- reset_n_i  in  1  reset; asynchronous, active-low.
- req_valid_i  in  NUM_REQ  per-requester request valid.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit high.
- req_a_i  in  NUM_REQ*DATA_W  packed A operands; requester k owns slice k.
- req_b_i  in  NUM_REQ*DATA_W  packed B operands.
- req_op_i  in  NUM_REQ*3  packed opcodes: 000 nop, 001 add, 010 and, 011 xor, 100 mul, 111 rst.
- resp_valid_o  out  NUM_REQ  one-cycle completion pulse to the owning requester.
- resp_result_o  out  2*DATA_W  result; valid only while a resp_valid_o bit is high.
- resp_error_o  out  1  timeout flag; qualified by resp_valid_o.
- alu_start_o  out  1  ALU start.
- alu_op_o  out  3  ALU opcode.
- alu_a_o, alu_b_o  out  DATA_W  ALU operands.
- alu_done_i  in  1  ALU completion.
- alu_result_i  in  2*DATA_W  ALU result.

## Operation
- States:
  - IDLE: no transaction in flight; arbitration enabled.
  - BUSY: ALU operation in flight.
  - RESP: one-cycle response state.
- Arbitration:
  - In IDLE, the pick is the first k with req_valid_i[k]=1, searching from ptr upward and wrapping.
  - req_ready_o[pick] is driven combinationally high. req_ready_o is all-zero outside IDLE.
- Accept: a transfer happens at an edge where req_valid_i[k] and req_ready_o[k] are both high. At that edge the block:
  - latches op, A and B into registers;
  - records owner = k;
  - sets ptr = (k+1) mod NUM_REQ.
- Requester rule: hold valid, op and operands stable until accepted. Deasserting valid before accept withdraws the request.
- Opcode dispatch after accept:
  - Opcodes 001–100: go to BUSY. alu_start_o is registered high, and alu_op_o/alu_a_o/alu_b_o carry the latched values.
  - Opcodes 000, 111, 101, 110: go straight to RESP with result 0. alu_start_o stays low.
- In BUSY, alu_start_o is held high until alu_done_i is sampled high. At that edge the block latches alu_result_i and moves to RESP.
- RESP:
  - resp_valid_o[owner]=1 for exactly one cycle, with resp_result_o = latched result.
  - alu_start_o is low.
  - Next state is IDLE.
- Responses have no backpressure.
- alu_done_i is ignored outside BUSY.
- ALU operand outputs hold their last value when idle.

## Timing
- Reset values (all outputs): alu_start_o, alu_op_o, alu_a_o, alu_b_o, resp_valid_o, resp_result_o and resp_error_o are 0.
- Reset internal state: state=IDLE, ptr=0, owner=0.
- An asynchronous reset mid-transaction drops the transaction: no response is issued and alu_start_o falls immediately.
- ALU op latency: accept at edge E0, alu_start_o high from E0. If alu_done_i is sampled at edge E0+L (L≥1), resp_valid_o is high in cycle E0+L..E0+L+1.
- Local op latency: resp_valid_o is high in the cycle after accept.
- Throughput: the next accept is no earlier than the edge ending RESP, so there are at least 2 cycles between accepts.
- Simultaneous requests: exactly one accept, chosen by ptr. A continuously asserted requester is granted within NUM_REQ transactions.
- ptr wraps from NUM_REQ-1 to 0.

## Configuration
Macro: TINY_ALU_ARB_TIMEOUT_EN.
- Defined:
  - A counter clears at accept and increments each BUSY cycle without done.
  - On reaching TIMEOUT_CYC, the block drops alu_start_o, enters RESP with result 0 and resp_error_o=1, and ignores any later alu_done_i for that transaction.
- Undefined:
  - BUSY waits indefinitely.
  - resp_error_o is constant 0 and no counter is present.

## Structure
- tiny_alu_pkg holds:
  - the opcode enum typedef (NOP, ADD, AND, XOR, MUL, RST);
  - the state enum (IDLE, BUSY, RESP);
  - localparam defaults for DATA_W and TIMEOUT_CYC.
- Sub-module tiny_alu_rr_pick: combinational round-robin selector with inputs valid vector and ptr, outputs one-hot grant and index. The top level holds the FSM, pointer, operand/result registers and watchdog.

## Test plan
- Reset: assert reset_n_i=0 mid-BUSY -> all outputs 0 at once; no resp_valid_o afterwards; first request after reset from requester 0 is accepted.
- Single add: requester 2 sends op=001, A=8'hFF, B=8'h01; ALU model asserts done 1 cycle after start -> resp_valid_o=4'b0100 for one cycle with resp_result_o=16'h0100.
- Round-robin: all four valid continuously with mul ops (3-cycle ALU) -> grant order 0,1,2,3,0; each resp_result_o equals A*B (e.g. 8'hFF*8'hFF = 16'hFE01).
- Local ops: requester 1 sends op=000 -> no alu_start_o pulse; resp_valid_o[1] in the cycle after accept; result 0.
- Timeout (macro defined, TIMEOUT_CYC=16): ALU model never asserts done -> alu_start_o drops and resp_valid_o pulses with resp_error_o=1 after 16 BUSY cycles; a late alu_done_i is ignored.
- Withdrawal: requester 3 raises then drops valid while BUSY for requester 0 -> requester 3 is never granted; ptr advances to 1.
